// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - steps a captured word through shift amounts 0..STEPS-1 via an external barrel shifter
// Each result is offered on a valid/ready output; the sequencer waits for acceptance before the next amount.
module shift_sequencer #(
  parameter int STEPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data_in,
  output logic [3:0] a,
  output logic [1:0] sel,
  input  logic [3:0] shift_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [1:0] out_amt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, STEP, HOLD, DONE} state_t;

  localparam logic [1:0] LAST_SEL = 2'(STEPS - 1);

  state_t     state, state_nx;
  logic [3:0] a_nx, out_data_nx;
  logic [1:0] sel_nx, out_amt_nx;
  logic       out_valid_nx;

  always_comb begin
    state_nx     = state;
    a_nx         = a;
    sel_nx       = sel;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    out_amt_nx   = out_amt;
    case (state)
      IDLE: begin
        if (start) begin
          a_nx     = data_in;
          sel_nx   = 2'd0;
          state_nx = STEP;
        end
      end
      STEP: begin
        out_data_nx  = shift_out;
        out_amt_nx   = sel;
        out_valid_nx = 1'b1;
        state_nx     = HOLD;
      end
      HOLD: begin
        // sel only advances on acceptance, so it never passes LAST_SEL within a run
        if (out_ready) begin
          out_valid_nx = 1'b0;
          if (sel == LAST_SEL) begin
            state_nx = DONE;
          end else begin
            sel_nx   = sel + 2'd1;
            state_nx = STEP;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // busy and done are registered decodes of the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= 4'd0;
      sel       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= 4'd0;
      out_amt   <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      a         <= a_nx;
      sel       <= sel_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      out_amt   <= out_amt_nx;
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer with a rotate-left barrel shifter stub
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst, out_ready;
  logic       start, start1;
  logic [3:0] data_in, data_in1;
  logic [3:0] a, a1, shift_out, shift_out1, out_data, out_data1;
  logic [1:0] sel, sel1, out_amt, out_amt1;
  logic       out_valid, out_valid1, busy, busy1, done, done1;

  int total = 0;
  int bad = 0;
  int done_cnt4 = 0;
  int done_cnt1 = 0;
  logic [5:0] q4[$];
  logic [5:0] q1[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] rotl(input logic [3:0] v, input logic [1:0] s);
    logic [7:0] d;
    d = {v, v} << s;
    return d[7:4];
  endfunction

  assign shift_out  = rotl(a, sel);
  assign shift_out1 = rotl(a1, sel1);

  shift_sequencer #(.STEPS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .a(a), .sel(sel),
    .shift_out(shift_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_amt(out_amt), .busy(busy), .done(done)
  );

  shift_sequencer #(.STEPS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in1), .a(a1), .sel(sel1),
    .shift_out(shift_out1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_amt(out_amt1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done4(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    if (!done) chk("done4_timeout", 32'(done), 32'd1);
  endtask

  logic        hp4, hp1;
  logic [11:0] pv4, pv1;
  logic [5:0]  e4, e1;

  always @(negedge clk) begin
    if (rst) begin
      hp4 = 1'b0;
    end else begin
      if (hp4) chk("hold_stable4", 32'({out_valid, out_amt, out_data, a, sel}), 32'({1'b1, pv4}));
      if (done) chk("done_valid_excl4", 32'(out_valid), 32'd0);
      if (out_valid && out_ready) begin
        if (q4.size() == 0) chk("unexpected_result4", 32'(out_valid), 32'd0);
        else begin
          e4 = q4.pop_front();
          chk("result4", 32'({out_amt, out_data}), 32'(e4));
        end
      end
      hp4 = out_valid && !out_ready;
      pv4 = {out_amt, out_data, a, sel};
      if (done) done_cnt4++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hp1 = 1'b0;
    end else begin
      if (hp1) chk("hold_stable1", 32'({out_valid1, out_amt1, out_data1, a1, sel1}), 32'({1'b1, pv1}));
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("unexpected_result1", 32'(out_valid1), 32'd0);
        else begin
          e1 = q1.pop_front();
          chk("result1", 32'({out_amt1, out_data1}), 32'(e1));
        end
      end
      hp1 = out_valid1 && !out_ready;
      pv1 = {out_amt1, out_data1, a1, sel1};
      if (done1) done_cnt1++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; out_ready = 1'b0;
    data_in = 4'd0; data_in1 = 4'd0;
    tick(); tick();
    chk("rst_outputs4", 32'({a, sel, out_valid, out_data, out_amt, busy, done}), 32'd0);
    chk("rst_outputs1", 32'({a1, sel1, out_valid1, out_data1, out_amt1, busy1, done1}), 32'd0);
    rst = 1'b0;
    tick();

    // basic run, consumer always ready
    q4.push_back({2'd0, 4'b1110}); q4.push_back({2'd1, 4'b1101});
    q4.push_back({2'd2, 4'b1011}); q4.push_back({2'd3, 4'b0111});
    out_ready = 1'b1; data_in = 4'b1110; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done4(40, n);
    chk("run_len", 32'(n), 32'd8);
    tick();
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("q_empty_t1", 32'(q4.size()), 32'd0);

    // stalled first result, then an ignored mid-run start
    q4.push_back({2'd0, 4'b0111}); q4.push_back({2'd1, 4'b1110});
    q4.push_back({2'd2, 4'b1101}); q4.push_back({2'd3, 4'b1011});
    out_ready = 1'b0; data_in = 4'b0111; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    chk("first_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) tick();
    chk("stall_data", 32'({out_valid, out_amt, out_data}), 32'({1'b1, 2'd0, 4'b0111}));
    out_ready = 1'b1;
    n = 0;
    while (q4.size() > 2 && n < 20) begin tick(); n++; end
    chk("two_accepted", 32'(q4.size()), 32'd2);
    start = 1'b1; data_in = 4'b0001;
    tick();
    start = 1'b0;
    chk("a_kept_midrun", 32'(a), 32'b0111);
    wait_done4(40, n);
    chk("a_kept_done", 32'(a), 32'b0111);
    tick();

    // abort while holding the amount-2 result
    q4.push_back({2'd0, 4'b0011}); q4.push_back({2'd1, 4'b0110});
    out_ready = 1'b1; data_in = 4'b0011; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (q4.size() > 0 && n < 20) begin tick(); n++; end
    out_ready = 1'b0;
    n = 0;
    while (!(out_valid && out_amt == 2'd2) && n < 10) begin tick(); n++; end
    chk("amt2_data", 32'({out_valid, out_amt, out_data}), 32'({1'b1, 2'd2, 4'b1100}));
    d = done_cnt4;
    rst = 1'b1;
    tick();
    chk("abort_outputs", 32'({a, sel, out_valid, out_data, out_amt, busy, done}), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_no_done", 32'(done_cnt4), 32'(d));
    q4.push_back({2'd0, 4'b1000}); q4.push_back({2'd1, 4'b0001});
    q4.push_back({2'd2, 4'b0010}); q4.push_back({2'd3, 4'b0100});
    out_ready = 1'b1; data_in = 4'b1000; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done4(40, n);
    tick();

    // start held high: back-to-back runs separated by one idle cycle
    for (int r = 0; r < 2; r++) begin
      q4.push_back({2'd0, 4'b0101}); q4.push_back({2'd1, 4'b1010});
      q4.push_back({2'd2, 4'b0101}); q4.push_back({2'd3, 4'b1010});
    end
    data_in = 4'b0101; start = 1'b1;
    tick();
    wait_done4(40, n);
    tick();
    chk("idle_gap", 32'(busy), 32'd0);
    tick();
    chk("restart_busy", 32'(busy), 32'd1);
    wait_done4(40, n);
    start = 1'b0;
    tick();
    chk("no_third_run_a", 32'(busy), 32'd0);
    tick();
    chk("no_third_run_b", 32'(busy), 32'd0);

    // single-step instance
    q1.push_back({2'd0, 4'b1010});
    data_in1 = 4'b1010; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 20) begin tick(); n++; end
    chk("steps1_len", 32'(n), 32'd2);
    tick();
    chk("steps1_idle", 32'(busy1), 32'd0);

    chk("q4_empty", 32'(q4.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("done_count4", 32'(done_cnt4), 32'd5);
    chk("done_count1", 32'(done_cnt1), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL provide parameter STEPS, default 4, number of shift amounts issued per run (legal 1..4, amounts 0..STEPS-1).
REQ-002 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide start  input  1  request to begin a run; sampled only in IDLE.
REQ-005 SHALL provide data_in  input  4  word to be shifted, captured on accepted start.
REQ-006 SHALL provide a  output  4  operand to the downstream barrel_shifter port a.
REQ-007 SHALL provide sel  output  2  shift amount to the barrel_shifter port sel.
REQ-008 SHALL provide shift_out  input  4  combinational result returned by barrel_shifter.
REQ-009 SHALL provide out_valid  output  1  result available on out_data and out_amt.
REQ-010 SHALL provide out_ready  input  1  consumer accepts the result when high with out_valid.
REQ-011 SHALL provide out_data  output  4  captured shift_out.
REQ-012 SHALL provide out_amt  output  2  sel value that produced out_data.
REQ-013 SHALL provide busy  output  1  high in any state other than IDLE.
REQ-014 SHALL provide done  output  1  one-cycle pulse at end of run.

Function
REQ-015 SHALL implement FSM states IDLE, STEP, HOLD, DONE; all outputs registered.
REQ-016 In IDLE with start=1 at an edge: a<=data_in, sel<=0, next state STEP; start=0 keeps IDLE.
REQ-017 In STEP: out_data<=shift_out, out_amt<=sel, out_valid<=1, next state HOLD (unconditional, one cycle).
REQ-018 In HOLD with out_ready=0: hold state; out_valid, out_data, out_amt, a, sel unchanged.
REQ-019 In HOLD with out_ready=1: out_valid<=0; if sel==STEPS-1 next state DONE, else sel<=sel+1 and next state STEP.
REQ-020 In DONE: done=1 for exactly that cycle; next state IDLE; sel and a retain last values.
REQ-021 First out_valid SHALL assert 2 cycles after the start-sampling edge; each further result 2 cycles after the previous acceptance.
REQ-022 With out_ready tied high, a run SHALL take 2*STEPS cycles in STEP/HOLD plus 1 DONE cycle.
REQ-023 start while busy=1 SHALL be ignored, not queued; start during DONE is also ignored.
REQ-024 a SHALL remain stable from capture until the next accepted start.
REQ-025 sel SHALL never exceed STEPS-1; no wrap from 3 to 0 within a run.
REQ-026 out_valid SHALL never deassert without an acceptance (out_ready=1) or reset.
REQ-027 done and out_valid SHALL never be high in the same cycle.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, a=0, sel=0, out_valid=0, out_data=0, out_amt=0, busy=0, done=0.
REQ-029 rst SHALL override start and out_ready in the same cycle and abort any run in progress; no done pulse for an aborted run.
REQ-030 After rst deasserts, the first start SHALL behave per REQ-016.

Verification (bench drives shift_out from a stub: shift_out = a rotated left by sel)
REQ-031 rst then data_in=4'b1110, start 1 cycle, out_ready=1 -> out_data 1110,1101,1011,0111 with out_amt 0,1,2,3; done one cycle after 4th acceptance; busy 0 next.
REQ-032 data_in=4'b0111, out_ready low 5 cycles on first result -> out_valid held, out_data=0111, out_amt=0 stable; then 1110,1101,1011 follow.
REQ-033 Mid-run (after out_amt=1 accepted) assert start with data_in=4'b0001 -> ignored; a stays 0111, run completes normally.
REQ-034 rst asserted while in HOLD with out_amt=2 -> next cycle all outputs 0, busy 0, no done; new start with 4'b1000 yields 1000,0001,0010,0100.
REQ-035 STEPS=1, data_in=4'b1010 -> single result 1010/amt 0, done 3 cycles after start edge with out_ready=1.
REQ-036 start held high continuously -> new run begins in the IDLE cycle after each done; never two runs overlapped.
